// File: rtl/uart_pkg.sv
// Shared state encodings, ASCII constants, error codes and payload type for
// the UART command decoder.
package uart_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TMO_W       = 32;
  localparam int unsigned DIG_W       = 3;
  localparam int unsigned ADDR_DIGITS = ADDR_W / 4;
  localparam int unsigned DATA_DIGITS = DATA_W / 4;

  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    S0_IDLE = 3'd0,
    S1_ADDR = 3'd1,
    S2_DATA = 3'd2,
    S3_CR   = 3'd3,
    S4_LF   = 3'd4,
    S5_EXEC = 3'd5,
    S6_ERR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_BAD_CHAR = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_BAD_OP   = 2'd2
  } err_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_payload_t;

  // Terminal count of the inter-byte timeout counter, in clock cycles.
  function automatic int unsigned timeout_clk(input int unsigned clk_freq,
                                              input int unsigned timeout_us);
    return (clk_freq / 32'd1_000_000) * timeout_us - 32'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / command-out bus between a UART receiver and the command decoder.
interface uart_cmd_decoder_if;
  import uart_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_vld;
  logic              cmd_wr;
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output rx_data, rx_vld,
    input  cmd_wr, cmd_rd, cmd_addr, cmd_wdata, cmd_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_vld,
    output cmd_wr, cmd_rd, cmd_addr, cmd_wdata, cmd_err, err_code, busy
  );

endinterface

// File: rtl/ascii_hex2nib.sv
// Combinational ASCII hex digit decoder (case-insensitive) to {valid, nibble}.
module ascii_hex2nib (
  input  logic [7:0] ascii,
  output logic       valid_c,
  output logic [3:0] nib_c
);

  always_comb begin
    valid_c = 1'b0;
    nib_c   = 4'd0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      valid_c = 1'b1;
      nib_c   = 4'(ascii - 8'h30);
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      valid_c = 1'b1;
      nib_c   = 4'(ascii - 8'h37);
    end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
      valid_c = 1'b1;
      nib_c   = 4'(ascii - 8'h57);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder_core.sv
// Frame parser FSM for "W<aa><dddddddd>\r\n" / "R<aa>\r\n" commands.
// Inter-byte timeout is compiled in only with UART_CMD_TIMEOUT_EN defined.
module uart_cmd_decoder_core
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLK = 32'd49_999
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_decoder_if.slave bus
);

  state_e           state;
  state_e           state_nxt;
  err_e             err_cause;
  logic             op_wr;
  logic [DIG_W-1:0] dig_cnt;
  cmd_payload_t     shadow;
  logic             hex_vld;
  logic [3:0]       hex_nib;
  logic             tmo_hit;

  logic             cmd_wr_d, cmd_rd_d, cmd_err_d, busy_d;
  cmd_payload_t     cmd_d;
  err_e             err_code_d;
  logic             cmd_wr_q, cmd_rd_q, cmd_err_q, busy_q;
  cmd_payload_t     cmd_q;
  err_e             err_code_q;

  if (TIMEOUT_CLK == 0) begin : g_cfg_chk
    $error("uart_cmd_decoder: timeout must be at least one clock cycle");
  end

  ascii_hex2nib u_hex2nib (
    .ascii   (bus.rx_data),
    .valid_c (hex_vld),
    .nib_c   (hex_nib)
  );

`ifdef UART_CMD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;

  assign in_frame = (state == S1_ADDR) || (state == S2_DATA) ||
                    (state == S3_CR)   || (state == S4_LF);

  // Cycles since the last accepted byte; an arriving byte always clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     tmo_cnt <= '0;
    else if (!in_frame || bus.rx_vld) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = in_frame && (tmo_cnt == TMO_W'(TIMEOUT_CLK));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S0_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_cause = ERR_BAD_CHAR;
    case (state)
      S0_IDLE: if (bus.rx_vld) begin
        if (bus.rx_data == ASCII_W || bus.rx_data == ASCII_R) begin
          state_nxt = S1_ADDR;
        end else if (bus.rx_data != ASCII_CR && bus.rx_data != ASCII_LF) begin
          state_nxt = S6_ERR;
          err_cause = ERR_BAD_OP;
        end
      end
      S1_ADDR: if (bus.rx_vld) begin
        if (!hex_vld)                                 state_nxt = S6_ERR;
        else if (dig_cnt == DIG_W'(ADDR_DIGITS - 1)) state_nxt = op_wr ? S2_DATA : S3_CR;
      end
      S2_DATA: if (bus.rx_vld) begin
        if (!hex_vld)                                 state_nxt = S6_ERR;
        else if (dig_cnt == DIG_W'(DATA_DIGITS - 1)) state_nxt = S3_CR;
      end
      S3_CR: if (bus.rx_vld) state_nxt = (bus.rx_data == ASCII_CR) ? S4_LF : S6_ERR;
      S4_LF: if (bus.rx_vld) state_nxt = (bus.rx_data == ASCII_LF) ? S5_EXEC : S6_ERR;
      S5_EXEC: state_nxt = S0_IDLE;
      S6_ERR:  state_nxt = S0_IDLE;
      default: state_nxt = S0_IDLE;
    endcase
    // A byte arriving on the terminal count takes priority over the timeout.
    if (tmo_hit && !bus.rx_vld) begin
      state_nxt = S6_ERR;
      err_cause = ERR_TIMEOUT;
    end
  end

  always_comb begin
    cmd_wr_d   = 1'b0;
    cmd_rd_d   = 1'b0;
    cmd_err_d  = 1'b0;
    busy_d     = (state_nxt != S0_IDLE);
    cmd_d      = cmd_q;
    err_code_d = err_code_q;
    if (state_nxt == S5_EXEC) begin
      cmd_wr_d   = op_wr;
      cmd_rd_d   = !op_wr;
      cmd_d.addr = shadow.addr;
      if (op_wr) cmd_d.wdata = shadow.wdata;
    end
    if (state_nxt == S6_ERR) begin
      cmd_err_d  = 1'b1;
      err_code_d = err_cause;
    end
  end

  // Opcode, digit counter and shadow shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr   <= 1'b0;
      dig_cnt <= '0;
      shadow  <= '0;
    end else begin
      if (state == S0_IDLE && state_nxt == S1_ADDR) op_wr <= (bus.rx_data == ASCII_W);
      if (state_nxt != state)          dig_cnt <= '0;
      else if (bus.rx_vld && hex_vld)  dig_cnt <= dig_cnt + DIG_W'(1);
      if (bus.rx_vld && hex_vld) begin
        if (state == S1_ADDR)      shadow.addr  <= {shadow.addr[ADDR_W-5:0], hex_nib};
        else if (state == S2_DATA) shadow.wdata <= {shadow.wdata[DATA_W-5:0], hex_nib};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q   <= 1'b0;
      cmd_rd_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      cmd_q      <= '0;
      err_code_q <= ERR_BAD_CHAR;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
      cmd_q      <= cmd_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.cmd_wr    = cmd_wr_q;
  assign bus.cmd_rd    = cmd_rd_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_addr  = cmd_q.addr;
  assign bus.cmd_wdata = cmd_q.wdata;
  assign bus.err_code  = err_code_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART ASCII command decoder top: flat receiver-facing ports around the parser.
// Optional inter-byte timeout enabled by macro UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic              cmd_wr,
  output logic              cmd_rd,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned TIMEOUT_CLK = timeout_clk(CLK_FREQ, TIMEOUT_US);

  uart_cmd_decoder_if bus ();

  assign bus.rx_data = rx_data;
  assign bus.rx_vld  = rx_vld;
  assign cmd_wr      = bus.cmd_wr;
  assign cmd_rd      = bus.cmd_rd;
  assign cmd_addr    = bus.cmd_addr;
  assign cmd_wdata   = bus.cmd_wdata;
  assign cmd_err     = bus.cmd_err;
  assign err_code    = bus.err_code;
  assign busy        = bus.busy;

  uart_cmd_decoder_core #(
    .TIMEOUT_CLK (TIMEOUT_CLK)
  ) u_core (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .bus   (bus.slave)
  );

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1000, meaning the inter-byte timeout in microseconds.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_vld  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port cmd_wr  output  1  one-cycle write strobe.
REQ-008 SHALL have port cmd_rd  output  1  one-cycle read strobe.
REQ-009 SHALL have port cmd_addr  output  8  decoded address; held until the next command.
REQ-010 SHALL have port cmd_wdata  output  32  decoded write data; held until the next write command.
REQ-011 SHALL have port cmd_err  output  1  one-cycle error strobe.
REQ-012 SHALL have port err_code  output  2  error cause; valid when cmd_err=1 and held afterwards.
REQ-013 SHALL have port busy  output  1  high in every state except S0_IDLE.

Function
REQ-014 SHALL accept frames "W"+2 hex+8 hex+"\r\n" (write) and "R"+2 hex+"\r\n" (read); hex digits are MSB first.
REQ-015 SHALL treat hex digits as case-insensitive: '0'-'9', 'A'-'F', 'a'-'f'.
REQ-016 SHALL use states S0_IDLE, S1_ADDR, S2_DATA, S3_CR, S4_LF, S5_EXEC, S6_ERR.
REQ-017 S0_IDLE: on 'W' or 'R', SHALL latch the opcode and go to S1_ADDR; '\r' or '\n' SHALL be ignored; any other byte SHALL go to S6_ERR with err_code=2 (bad opcode).
REQ-018 S1_ADDR: after 2 valid hex digits, SHALL go to S2_DATA for a write or S3_CR for a read.
REQ-019 S2_DATA: after 8 valid hex digits, SHALL go to S3_CR.
REQ-020 S3_CR SHALL require '\r' and S4_LF SHALL require '\n'; a correct byte in S4_LF SHALL go to S5_EXEC.
REQ-021 In S1–S4, a wrong or non-hex byte SHALL go to S6_ERR with err_code=0 (bad char).
REQ-022 S5_EXEC SHALL last 1 cycle and assert cmd_wr or cmd_rd per the opcode, i.e. the cycle after the edge that samples '\n'; it SHALL then go to S0_IDLE.
REQ-023 S6_ERR SHALL last 1 cycle, assert cmd_err, then go to S0_IDLE.
REQ-024 cmd_addr and cmd_wdata SHALL be shift-assembled into shadow registers and copied to the outputs only on entry to S5_EXEC; a partial frame SHALL NOT disturb the outputs.
REQ-025 Timeout: in S1–S4, SHALL count cycles since the last rx_vld; at TIMEOUT_CLK = CLK_FREQ/1_000_000*TIMEOUT_US - 1 it SHALL go to S6_ERR with err_code=1.
REQ-026 If rx_vld coincides with the terminal count, the byte SHALL win and the counter SHALL clear.
REQ-027 rx_vld during S5_EXEC or S6_ERR SHALL be dropped; at UART rates bytes are more than 400 cycles apart.
REQ-028 The timeout counter SHALL be 32 bits and held at 0 in S0, S5 and S6.

Reset
REQ-029 On reset, state SHALL be S0_IDLE and cmd_wr, cmd_rd, cmd_err, busy SHALL be 0.
REQ-030 On reset, cmd_addr, cmd_wdata, err_code, the shadow registers and the counters SHALL be 0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no strobe issued.

Configuration
REQ-032 The timeout logic SHALL be compiled in only when macro UART_CMD_TIMEOUT_EN is defined.
REQ-033 Without UART_CMD_TIMEOUT_EN, the counter SHALL be absent, err_code=1 SHALL never occur, and a partial frame SHALL wait indefinitely.

Structure
REQ-034 Package uart_pkg SHALL hold the state encodings, ASCII constants ('W','R','\r','\n') and err_code values.
REQ-035 Sub-module ascii_hex2nib (combinational) SHALL map a byte to {valid, nibble[3:0]}.

Verification
REQ-036 Bytes "W1A0000BEEF\r\n" -> one-cycle cmd_wr after '\n', cmd_addr=0x1A, cmd_wdata=0x0000BEEF, no cmd_err.
REQ-037 Bytes "r" is not accepted; "Rff\r\n" -> cmd_rd pulse, cmd_addr=0xFF, cmd_wdata unchanged.
REQ-038 Bytes "W1G" -> cmd_err with err_code=0 on 'G'; the following "R05\r\n" -> cmd_rd with cmd_addr=0x05.
REQ-039 "W12" then silence 50_001 cycles (defaults, macro on) -> cmd_err with err_code=1, cmd_addr unchanged; with the macro off -> no error and busy stays 1.
REQ-040 Byte 'X' in idle -> err_code=2; "\r\n" in idle -> no strobe; reset asserted after "W12345" -> all outputs 0, no strobe.
